multicycle_control: RTL

Control FSM that sequences a shared-resource multicycle variant of the team's MIPS datapath. One unified memory serves instruction and data, and one ALU handles PC+4, branch target and execute. The block replaces the single-cycle Control plus branch AND/OR gating. It drives all mux selects and write enables per state, stalls on a memory ready handshake, counts retired instructions and traps on illegal opcodes or memory timeout.

---
 rtl/mips_mc_pkg.sv | 65 ++++++
 rtl/mc_dispatch.sv | 26 ++
 rtl/multicycle_control.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM:
// opcodes, states, ALU operations and datapath mux selects.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_ALU_WB    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_JAL       = 4'd12,
        S_JR        = 4'd13,
        S_TRAP      = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_RTYPE = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_AND   = 3'd4;
    localparam logic [2:0] ALU_LUI   = 3'd5;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_REG    = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_dispatch.sv
// Opcode dispatch: picks the state that follows DECODE and
// flags opcodes the datapath cannot execute.
module mc_dispatch
    import mips_mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output state_t     next_state,
    output logic       illegal
);

    always_comb begin
        next_state = S_TRAP;
        illegal    = 1'b0;
        case (op)
            OP_RTYPE: next_state = (funct == FUNCT_JR) ? S_JR : S_EXEC_R;
            OP_LW, OP_SW: next_state = S_MEM_ADDR;
            OP_BEQ, OP_BNE: next_state = S_BRANCH;
            OP_J: next_state = S_JUMP;
            OP_JAL: next_state = S_JAL;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: next_state = S_EXEC_I;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory stall handling,
// timeout/illegal-opcode trap and retired-instruction counter.
module multicycle_control
    import mips_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state_out,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

    state_t            state, next_state, disp_state;
    logic              disp_illegal;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_state, stall, timeout, retire;

    mc_dispatch u_dispatch (
        .op         (op),
        .funct      (funct),
        .next_state (disp_state),
        .illegal    (disp_illegal)
    );

    assign mem_state = (state == S_FETCH) || (state == S_MEM_READ) ||
                       (state == S_MEM_WRITE);
    assign stall     = mem_state && !mem_ready;
    // Trap on the stall cycle that would bring the count to the limit
    assign timeout   = (MEM_TIMEOUT != 0) && stall &&
                       (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign retire    = (next_state == S_FETCH) && (state != S_FETCH) &&
                       (state != S_IDLE);
    assign state_out = state;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      next_state = S_FETCH;
            S_FETCH:     if (mem_ready) next_state = S_DECODE;
            S_DECODE:    next_state = disp_state;
            S_MEM_ADDR:  next_state = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) next_state = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) next_state = S_FETCH;
            S_EXEC_R:    next_state = S_ALU_WB;
            S_EXEC_I:    next_state = S_ALU_WB;
            S_TRAP:      next_state = S_TRAP;
            default:     next_state = S_FETCH;
        endcase
        if (timeout)
            next_state = S_TRAP;
    end

    always_comb begin
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = WB_ALUOUT;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_ADD;
        pc_source  = PCS_ALU;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = SRCB_IMMSH;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = WB_MDR;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTYPE;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_LUI:  alu_op = ALU_LUI;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = (op == OP_RTYPE) ? DST_RD : DST_RT;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = PCS_ALUOUT;
                pc_write  = ((op == OP_BEQ) && zero) ||
                            ((op == OP_BNE) && !zero);
            end
            S_JUMP: begin
                pc_source = PCS_JUMP;
                pc_write  = 1'b1;
            end
            S_JAL: begin
                pc_source  = PCS_JUMP;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = DST_RA;
                mem_to_reg = WB_PC;
            end
            S_JR: begin
                pc_source = PCS_REG;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            trap        <= 1'b0;
            trap_cause  <= CAUSE_NONE;
            instr_count <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= stall ? wait_cnt + WAIT_W'(1) : '0;
            if (state != S_TRAP && next_state == S_TRAP) begin
                trap       <= 1'b1;
                trap_cause <= timeout ? CAUSE_TIMEOUT : CAUSE_ILLEGAL;
            end
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule
